// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - access-size encodings carried on i_memSize
//   - responder FSM state type
//   - lane_mask(): byte-write-enable pattern for a size / low-address pair
package dmem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;
   localparam logic [1:0] MEM_RSVD = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } dmem_state_e;

   // lo is expected to be already aligned for the access size.
   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] mask;
      case (size)
         MEM_BYTE: mask = 4'b0001 << lo;
         MEM_HALF: mask = 4'b0011 << {lo[1], 1'b0};
         MEM_WORD: mask = 4'b1111;
         default:  mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the core MEM stage and the
// data-memory responder.
//   master (core):      drives i_req, i_we, i_addr, i_wdata, i_memSize
//   slave  (responder): drives o_ready, o_busy, o_rvalid, o_rdata, o_err
interface dmem_responder_if;

   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [1:0]  i_memSize;
   logic        o_ready;
   logic        o_busy;
   logic        o_rvalid;
   logic [31:0] o_rdata;
   logic        o_err;

   modport master (
      output i_req, i_we, i_addr, i_wdata, i_memSize,
      input  o_ready, o_busy, o_rvalid, o_rdata, o_err
   );

   modport slave (
      input  i_req, i_we, i_addr, i_wdata, i_memSize,
      output o_ready, o_busy, o_rvalid, o_rdata, o_err
   );

endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH_WORDS x 32 storage with per-byte write enables and an
// asynchronous (combinational) read port. Contents are never reset.
//   clk_i    clock
//   waddr_i  write word index
//   wbe_i    byte-lane write enables (bit n writes wdata_i[8n+7:8n])
//   wdata_i  write data, already replicated into the target lanes
//   raddr_i  read word index
//   rdata_o  read data
module dmem_ram #(
   parameter int unsigned DEPTH_WORDS = 4096,
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic          clk_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [3:0]    wbe_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (wbe_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory slave for the core MEM stage.
// One request is accepted in IDLE, held for LATENCY cycles and answered with a
// single-cycle o_rvalid strobe. Stores commit on the RESP edge; loads read in RESP.
//   clk, reset  clock and asynchronous active-high reset
//   bus         dmem_responder_if.slave (request in, ready/busy/response out)
// Build option: define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses as errors; otherwise the low address bits are forced to alignment.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0002_0000,
   parameter int unsigned LATENCY     = 2
) (
   input logic              clk,
   input logic              reset,
   dmem_responder_if.slave  bus
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
   localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   dmem_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;

   logic          in_range;
   logic          misalign;
   logic          acc_err;
   logic [1:0]    lo;
   logic [AW-1:0] word_idx;
   logic [3:0]    ram_wbe;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [31:0]   shifted;
   logic [31:0]   load_data;

   // ---------------- next state ----------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      size_d  = size_q;
      unique case (state_q)
         StIdle: begin
            if (bus.i_req) begin
               addr_d  = bus.i_addr;
               wdata_d = bus.i_wdata;
               we_d    = bus.i_we;
               size_d  = bus.i_memSize;
               cnt_d   = CNT_INIT;
               state_d = (LATENCY == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            // Leaving on the cycle cnt hits 0 keeps WAIT at LATENCY-1 cycles.
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         size_q  <= size_d;
      end
   end

   // ---------------- address decode ----------------
   // Compare in 33 bits before subtracting so nothing wraps.
   assign in_range = ({1'b0, addr_q} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_q} < LIMIT);
   assign word_idx = AW'((addr_q - BASE_ADDR) >> 2);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = ((size_q == MEM_HALF) && addr_q[0]) ||
                     ((size_q == MEM_WORD) && (addr_q[1:0] != 2'b00));
   assign lo       = addr_q[1:0];
`else
   assign misalign = 1'b0;
   always_comb begin
      case (size_q)
         MEM_HALF: lo = {addr_q[1], 1'b0};
         MEM_WORD: lo = 2'b00;
         default:  lo = addr_q[1:0];
      endcase
   end
`endif

   assign acc_err = !in_range || (size_q == MEM_RSVD) || misalign;

   // ---------------- data alignment ----------------
   always_comb begin
      case (size_q)
         MEM_BYTE: ram_wdata = {4{wdata_q[7:0]}};
         MEM_HALF: ram_wdata = {2{wdata_q[15:0]}};
         default:  ram_wdata = wdata_q;
      endcase
   end

   // reset gates the write so a reset landing on the RESP edge drops the store.
   assign ram_wbe = ((state_q == StResp) && we_q && !acc_err && !reset) ?
                    lane_mask(size_q, lo) : 4'b0000;

   assign shifted = ram_rdata >> {lo, 3'b000};

   always_comb begin
      case (size_q)
         MEM_BYTE: load_data = {24'd0, shifted[7:0]};
         MEM_HALF: load_data = {16'd0, shifted[15:0]};
         default:  load_data = shifted;
      endcase
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk_i   (clk),
      .waddr_i (word_idx),
      .wbe_i   (ram_wbe),
      .wdata_i (ram_wdata),
      .raddr_i (word_idx),
      .rdata_o (ram_rdata)
   );

   // ---------------- outputs ----------------
   assign bus.o_ready  = (state_q == StIdle);
   assign bus.o_busy   = ((state_q == StIdle) && bus.i_req) || (state_q == StWait);
   assign bus.o_rvalid = (state_q == StResp);
   assign bus.o_err    = (state_q == StResp) && acc_err;
   assign bus.o_rdata  = ((state_q == StResp) && !we_q && !acc_err) ? load_data : 32'd0;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, SHALL set the number of 32-bit words in the memory array.
REQ-002 Parameter BASE_ADDR, default 32'h0002_0000, SHALL set the byte address of word 0.
REQ-003 Parameter LATENCY, default 2, SHALL set the number of cycles from accept to response; legal range is 1..15.
REQ-004 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1: asynchronous, active-high reset.
REQ-006 Port i_req  in  1: request valid from the core MEM stage.
REQ-007 Port i_we  in  1: 1 = store, 0 = load.
REQ-008 Port i_addr  in  32: byte address.
REQ-009 Port i_wdata  in  32: store data, LSB-aligned.
REQ-010 Port i_memSize  in  2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-011 Port o_ready  out  1: a request is accepted this cycle when i_req and o_ready are both high.
REQ-012 Port o_busy  out  1: stall request to the hazard unit.
REQ-013 Port o_rvalid  out  1: one-cycle response strobe, for loads and stores.
REQ-014 Port o_rdata  out  32: load data, shifted so the addressed byte sits at bits [7:0]; zero-filled above the access size and not sign-extended.
REQ-015 Port o_err  out  1: error flag, valid only while o_rvalid is high.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 o_ready SHALL be 1 only in IDLE.
REQ-018 An accept in IDLE SHALL latch addr, wdata, we and memSize, load cnt = LATENCY-1, and go to WAIT, or to RESP when LATENCY = 1.
REQ-019 WAIT SHALL decrement cnt each cycle and go to RESP when cnt reaches 0.
REQ-020 RESP SHALL last exactly one cycle with o_rvalid = 1, then return to IDLE; o_rvalid is therefore high LATENCY cycles after the accept edge.
REQ-021 A store SHALL commit to memory on the RESP clock edge, writing only the byte lanes selected by memSize and addr[1:0].
REQ-022 A load SHALL read the array during RESP, so o_rdata reflects any store committed earlier.
REQ-023 o_busy SHALL equal (state==IDLE && i_req) || state==WAIT; it is combinational, so the core stalls in the accept cycle.
REQ-024 While state is not IDLE, i_req SHALL be ignored and no second request SHALL be queued.
REQ-025 An address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) SHALL give o_err = 1 and o_rdata = 0, and the store SHALL be dropped.
REQ-026 memSize = 11 SHALL be handled exactly as an out-of-range access.
REQ-027 The word index SHALL be (addr - BASE_ADDR) >> 2, with 32-bit wrap-free subtraction (compare before subtracting).
REQ-028 o_rdata SHALL be 0 and o_err SHALL be 0 whenever o_rvalid = 0.

Reset
REQ-029 While reset is high: state = IDLE, cnt = 0, latched request = 0, o_ready = 1, o_rvalid = 0, o_err = 0, o_rdata = 0; o_busy follows i_req (REQ-023).
REQ-030 A reset asserted during WAIT or RESP SHALL drop the pending request, and no store SHALL commit.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 Macro DMEM_MISALIGN_TRAP_EN defined: a half access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL give o_err = 1 and o_rdata = 0, and the store SHALL be dropped.
REQ-033 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be forced to zero (half ignores addr[0], word ignores addr[1:0]), and no error SHALL be raised for misalignment.

Structure
REQ-034 Package dmem_pkg SHALL hold the MEM_BYTE/MEM_HALF/MEM_WORD/MEM_RSVD encodings, the state enum, and the lane-mask function.
REQ-035 Sub-module dmem_ram SHALL implement a DEPTH_WORDS x 32 array with a 4-bit byte-write-enable port and a combinational read port.
REQ-036 All handshake, FSM, address decode and data alignment logic SHALL reside in dmem_responder.

Verification
REQ-037 LATENCY=2: store word 32'hDEADBEEF at BASE_ADDR+8, then load word at BASE_ADDR+8 -> each o_rvalid 2 cycles after its accept, and the load returns 32'hDEADBEEF with o_err = 0.
REQ-038 Store byte 8'hA5 at BASE_ADDR+0xB, then load word at BASE_ADDR+8 -> 32'hA5ADBEEF; load half at BASE_ADDR+0xA -> 32'h0000A5AD.
REQ-039 i_req held high for 6 cycles with LATENCY=2 -> accepts occur at cycles 0 and 3 only, and o_busy is high in cycles 0, 1, 3, 4.
REQ-040 Load at BASE_ADDR-4, and separately a load with memSize = 11 -> o_err = 1 and o_rdata = 0; a store at BASE_ADDR+4*DEPTH_WORDS leaves memory unchanged.
REQ-041 Reset pulsed during WAIT of a store to BASE_ADDR+0 -> no o_rvalid, the word keeps its old value, and the next request is accepted in IDLE.
REQ-042 Word load at BASE_ADDR+2 -> o_err = 1 with DMEM_MISALIGN_TRAP_EN defined; the word at BASE_ADDR+0 with o_err = 0 without it.
